// File: rtl/sram_arb_pkg.sv
// Shared types and default sizes for the SRAM port arbiter.
package sram_arb_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 10;

  typedef enum logic [1:0] {
    IDLE,
    RMW_RD,
    RMW_WR
  } arb_state_t;

  // Which port receives the read data returning in the following cycle.
  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } owner_t;

endpackage

// File: rtl/sram_byte_merge.sv
// Byte-lane merge of store data into an existing word under a byte-enable mask.
module sram_byte_merge
  import sram_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0]   old_word,
  input  logic [DATA_WIDTH-1:0]   new_word,
  input  logic [DATA_WIDTH/8-1:0] be,
  output logic [DATA_WIDTH-1:0]   merged
);

  always_comb begin
    merged = old_word;
    for (int unsigned b = 0; b < DATA_WIDTH / 8; b++) begin
      if (be[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin sharing of one SRAM port between fetch and load/store ports,
// with partial-word stores executed as an internal read-modify-write.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  localparam int unsigned BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [BE_WIDTH-1:0]   d_be,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  arb_state_t            state_q, state_d;
  owner_t                owner_q, owner_d;
  logic                  prio_d_q, prio_d_d;  // 1: data port wins a tie
  logic                  rmw_latch;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BE_WIDTH-1:0]   be_q;
  logic [DATA_WIDTH-1:0] wdata_q, merged_q, merged_w;
  logic [DATA_WIDTH-1:0] i_rdata_q, d_rdata_q;

  sram_byte_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
    .old_word (sram_dout),
    .new_word (wdata_q),
    .be       (be_q),
    .merged   (merged_w)
  );

  // Grants are gated by rst_n so every output reads as its reset value while reset is held.
  always_comb begin
    state_d   = state_q;
    owner_d   = OWN_NONE;
    prio_d_d  = prio_d_q;
    rmw_latch = 1'b0;
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    sram_csb  = 1'b1;
    sram_web  = 1'b1;
    sram_addr = '0;
    sram_din  = '0;
    unique case (state_q)
      IDLE: begin
        if (rst_n) begin
          if (d_req && (!i_req || prio_d_q)) begin
            d_gnt    = 1'b1;
            prio_d_d = 1'b0;
            if (!d_we) begin
              sram_csb  = 1'b0;
              sram_addr = d_addr;
              owner_d   = OWN_D;
            end else if (&d_be) begin
              sram_csb  = 1'b0;
              sram_web  = 1'b0;
              sram_addr = d_addr;
              sram_din  = d_wdata;
            end else if (|d_be) begin
              sram_csb  = 1'b0;
              sram_addr = d_addr;
              rmw_latch = 1'b1;
              state_d   = RMW_RD;
            end
          end else if (i_req) begin
            i_gnt     = 1'b1;
            prio_d_d  = 1'b1;
            sram_csb  = 1'b0;
            sram_addr = i_addr;
            owner_d   = OWN_I;
          end
        end
      end
      RMW_RD: state_d = RMW_WR;
      RMW_WR: begin
        sram_csb  = 1'b0;
        sram_web  = 1'b0;
        sram_addr = addr_q;
        sram_din  = merged_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= OWN_NONE;
      prio_d_q  <= 1'b1;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      merged_q  <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      prio_d_q <= prio_d_d;
      if (rmw_latch) begin
        addr_q  <= d_addr;
        be_q    <= d_be;
        wdata_q <= d_wdata;
      end
      if (state_q == RMW_RD) merged_q <= merged_w;
      if (owner_q == OWN_I) i_rdata_q <= sram_dout;
      if (owner_q == OWN_D) d_rdata_q <= sram_dout;
    end
  end

  // Read data flows straight from the macro in the response cycle, then is held.
  assign i_rvalid = (owner_q == OWN_I);
  assign d_rvalid = (owner_q == OWN_D);
  assign i_rdata  = i_rvalid ? sram_dout : i_rdata_q;
  assign d_rdata  = d_rvalid ? sram_dout : d_rdata_q;

endmodule
